// File: rtl/iopage_pkg.sv
// Shared types and constants for the PDP-11 I/O page arbiter.
package iopage_pkg;

  localparam int unsigned IopageAw         = 13;
  localparam int unsigned NxmCyclesDefault = 8;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StResp
  } iopage_state_e;

  typedef struct packed {
    logic [IopageAw-1:0] addr;
    logic                wr;
    logic                byte_op;
    logic [15:0]         wdata;
  } xfer_req_t;

  // Right-justify the addressed byte of a device word on byte reads.
  function automatic logic [15:0] rd_align(input logic [15:0] d, input logic byte_op,
                                           input logic odd);
    if (!byte_op) return d;
    if (odd) return {8'h00, d[15:8]};
    return {8'h00, d[7:0]};
  endfunction

  // Byte writes to odd addresses replicate the low byte onto the high lane.
  function automatic logic [15:0] wr_lanes(input logic [15:0] d, input logic byte_op,
                                           input logic odd);
    if (byte_op && odd) return {d[7:0], d[7:0]};
    return d;
  endfunction

endpackage

// File: rtl/iopage_arb_if.sv
// Requester and device-side signals of the I/O page arbiter.
interface iopage_arb_if
  import iopage_pkg::*;
#(
  parameter int unsigned NDEV = 4
);
  logic                  req0;
  logic                  req1;
  logic [IopageAw-1:0]   addr0;
  logic [IopageAw-1:0]   addr1;
  logic                  wr0;
  logic                  wr1;
  logic                  byte0;
  logic                  byte1;
  logic [15:0]           wdata0;
  logic [15:0]           wdata1;
  logic                  ack0;
  logic                  ack1;
  logic                  err0;
  logic                  err1;
  logic [15:0]           rdata;

  logic [IopageAw-1:0]   iopage_addr;
  logic                  iopage_rd;
  logic                  iopage_wr;
  logic                  iopage_byte_op;
  logic [15:0]           iopage_wdata;
  logic [NDEV-1:0]       dev_decode;
  logic [16*NDEV-1:0]    dev_rdata;

  // Environment side: requesters plus attached devices.
  modport master (
    output req0, req1, addr0, addr1, wr0, wr1, byte0, byte1, wdata0, wdata1,
    output dev_decode, dev_rdata,
    input  ack0, ack1, err0, err1, rdata,
    input  iopage_addr, iopage_rd, iopage_wr, iopage_byte_op, iopage_wdata
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, addr0, addr1, wr0, wr1, byte0, byte1, wdata0, wdata1,
    input  dev_decode, dev_rdata,
    output ack0, ack1, err0, err1, rdata,
    output iopage_addr, iopage_rd, iopage_wr, iopage_byte_op, iopage_wdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; priority flips to the other port after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  // prio_q names the port that wins a tie; port 0 after reset.
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || !prio_q)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
endmodule

// File: rtl/iopage_arb.sv
// Two-port I/O page bus sequencer: arbitrates, drives device strobes, muxes read data,
// and aborts with a non-existent-memory error when no device decodes the address.
module iopage_arb
  import iopage_pkg::*;
#(
  parameter int unsigned NDEV       = 4,
  parameter int unsigned NXM_CYCLES = NxmCyclesDefault
) (
  input logic         clk,
  input logic         reset,
  iopage_arb_if.slave bus
);
  localparam int unsigned    CntW    = (NXM_CYCLES > 1) ? $clog2(NXM_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NXM_CYCLES - 1);

  iopage_state_e   state_q, state_d;
  logic            port_q, port_d;
  xfer_req_t       req_q, req_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [15:0]     rdata_q, rdata_d;

  logic [1:0]  gnt;
  logic        idle;
  logic        xfer;
  logic        resp;
  logic        any_dec;
  logic [15:0] sel_data;

  assign idle    = (state_q == StIdle);
  assign xfer    = (state_q == StXfer);
  assign resp    = (state_q == StResp);
  assign any_dec = |bus.dev_decode;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .en    (idle),
    .req   ({bus.req1, bus.req0}),
    .gnt   (gnt)
  );

  // Lowest-index decoding device wins when several claim the address.
  always_comb begin
    sel_data = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (bus.dev_decode[i]) begin
        sel_data = bus.dev_rdata[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          port_d  = gnt[1];
          req_d   = gnt[1] ? {bus.addr1, bus.wr1, bus.byte1, bus.wdata1}
                           : {bus.addr0, bus.wr0, bus.byte0, bus.wdata0};
          cnt_d   = '0;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (any_dec) begin
          err_d   = 1'b0;
          rdata_d = req_q.wr ? 16'h0000 : rd_align(sel_data, req_q.byte_op, req_q.addr[0]);
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      port_q  <= 1'b0;
      req_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Device-side outputs are only live during XFER; the write strobe waits for a decode.
  always_comb begin
    bus.iopage_addr    = '0;
    bus.iopage_rd      = 1'b0;
    bus.iopage_wr      = 1'b0;
    bus.iopage_byte_op = 1'b0;
    bus.iopage_wdata   = '0;
    if (xfer) begin
      bus.iopage_addr    = req_q.addr;
      bus.iopage_rd      = !req_q.wr;
      bus.iopage_wr      = req_q.wr && any_dec;
      bus.iopage_byte_op = req_q.byte_op;
      bus.iopage_wdata   = wr_lanes(req_q.wdata, req_q.byte_op, req_q.addr[0]);
    end
  end

  always_comb begin
    bus.ack0  = resp && !err_q && !port_q;
    bus.ack1  = resp && !err_q && port_q;
    bus.err0  = resp && err_q && !port_q;
    bus.err1  = resp && err_q && port_q;
    bus.rdata = resp ? rdata_q : 16'h0000;
  end
endmodule

// File: doc/iopage_arb.md
# iopage_arb

Arbitrates and sequences access to the shared PDP-11 I/O page bus between two requesters: CPU (port 0) and console/DMA (port 1). Drives the device-side address, strobes and write data, muxes read data from up to `NDEV` register devices by their `decode` lines, and aligns bytes. A no-response timeout reports a non-existent-memory error so the CPU can trap to vector 4. Sits between the bus unit and the I/O page register devices.

## Interface
- `NDEV`, 4, number of attached I/O page devices
- `NXM_CYCLES`, 8, cycles without any decode before a transfer aborts with error (min 1)
- `clk` in 1 — one clock; all state on rising edge
- `reset` in 1 — asynchronous, active-low
- `req0`/`req1` in 1 — transfer request, held high until `ack`/`err` of that port
- `addr0`/`addr1` in 13 — I/O page byte address
- `wr0`/`wr1` in 1 — 1 write, 0 read
- `byte0`/`byte1` in 1 — byte operation
- `wdata0`/`wdata1` in 16 — write data (byte data in [7:0])
- `ack0`/`ack1` out 1 — one-cycle completion pulse
- `err0`/`err1` out 1 — one-cycle NXM pulse
- `rdata` out 16 — read data, valid only with `ack`/`err`
- `iopage_addr` out 13; `iopage_rd`, `iopage_wr`, `iopage_byte_op` out 1; `iopage_wdata` out 16
- `dev_decode` in NDEV — device decode lines (combinational from `iopage_addr`)
- `dev_rdata` in 16*NDEV — device read data, device i at [16i+15:16i]

## Operation
- FSM states: IDLE, XFER, RESP.
- IDLE: if any req, round-robin pick (port not granted last wins ties; after reset port 0 wins); latch addr/wr/byte/wdata into registers; -> XFER; clear timeout counter.
- XFER: `iopage_addr` = latched addr; `iopage_rd` = !wr; `iopage_byte_op` = byte. `any` = OR of `dev_decode`.
  - `any`=1: `iopage_wr` = wr for this cycle only (combinational qualify by `any`); on read capture selected device data (lowest-index asserted decode); -> RESP with ack.
  - `any`=0: counter++; when counter reaches `NXM_CYCLES` -> RESP with err, `rdata`=0, no write strobe issued.
- RESP: pulse granted port's `ack` or `err` for one cycle, other port's flags 0; -> IDLE.
- Byte rules: byte write to odd addr: `iopage_wdata` = {wdata[7:0], wdata[7:0]}; even: wdata passed. Byte read odd addr: `rdata` = {8'h00, dev[15:8]}; even: {8'h00, dev[7:0]}. Word ops: addr[0] ignored, data passed.
- Multiple decodes asserted: lowest index wins; not an error.
- Outside XFER all `iopage_*` outputs are 0.

## Timing
- Reset (any time, including mid-XFER): state IDLE, all outputs 0, round-robin pointer to port 0, counter 0; an aborted transfer gets no ack/err.
- Minimum transaction: req seen high at edge 0 -> XFER in cycle 1 -> `ack`+`rdata` in cycle 2 -> IDLE cycle 3. Latency 2 cycles request-to-ack.
- NXM: `err` in cycle 1+`NXM_CYCLES`.
- Requester must drop req on the edge that samples its ack/err; a still-high req in IDLE starts a new transfer.
- Both reqs high in same IDLE cycle: one granted, other waits; back-to-back transfers alternate ports.
- Write strobe is at most one cycle per transfer.

## Structure
- Package `iopage_pkg`: state enum (IDLE/XFER/RESP), I/O page address width 13, default NXM_CYCLES.
- Sub-module `rr_arb2`: two-request round-robin with registered last-grant pointer, advanced only on grant.

## Test plan
- Port 0 read of 13'o17570, device 0 decodes with data 16'o123456 -> `ack0` in cycle 2, `rdata`=16'o123456, `iopage_rd` high exactly one cycle.
- Port 1 byte write 8'hA5 to odd address, device decodes -> `iopage_wdata`=16'hA5A5, `iopage_byte_op`=1, `iopage_wr` one cycle, `ack1`.
- Byte read odd address, device data 16'h1234 -> `rdata`=16'h0012.
- Read of undecoded address with NXM_CYCLES=8 -> `err0` in cycle 9, `rdata`=0, `iopage_wr` never high.
- Both ports request continuously for 4 transfers -> grant order 0,1,0,1, one ack per transfer.
- Reset asserted in XFER -> all outputs 0 immediately, no ack/err; next request after release granted to port 0 first.
